// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave exposing NREGS 32-bit control registers
// (slv_reg) and NREGS status words (slv_read), with per-register write/read
// pulses, byte strobes and SLVERR on out-of-range indices.
// Optional build macro AXIL_REGBANK_ID_EN: read index 0 returns ID_VAL.
module axi_lite_regbank #(
    parameter int          NREGS   = 16,
    parameter int          ADDR_W  = 6,
    parameter logic [31:0] RST_VAL = 32'h0000_0000,
    parameter logic [31:0] ID_VAL  = 32'hDEAD_BEEF
) (
    input  logic                axi_clk,
    input  logic                axi_aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [NREGS*32-1:0] slv_reg,
    input  logic [NREGS*32-1:0] slv_read,
    output logic [NREGS-1:0]    slv_wr_pulse,
    output logic [NREGS-1:0]    slv_rd_pulse
);

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // ---------------- write path ----------------
    wstate_t          r_wstate, w_wstate_nxt;
    logic             r_aw_have, r_w_have, w_aw_have_nxt, w_w_have_nxt;
    logic             r_awready, r_wready;
    logic [IDX_W-1:0] r_widx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [1:0]       r_bresp;
    logic [31:0]      r_regs [NREGS];
    logic             w_aw_hs, w_w_hs, w_widx_ok;

    assign w_aw_hs   = s_axi_awvalid & r_awready;
    assign w_w_hs    = s_axi_wvalid & r_wready;
    assign w_widx_ok = int'(r_widx) < NREGS;

    // Write FSM next state, AW/W capture flags and write-side outputs
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_have_nxt = r_aw_have;
        w_w_have_nxt  = r_w_have;
        slv_wr_pulse  = '0;
        case (r_wstate)
            W_IDLE: begin
                w_aw_have_nxt = r_aw_have | w_aw_hs;
                w_w_have_nxt  = r_w_have | w_w_hs;
                if (w_aw_have_nxt && w_w_have_nxt) begin
                    w_wstate_nxt  = W_EXEC;
                    w_aw_have_nxt = 1'b0;
                    w_w_have_nxt  = 1'b0;
                end
            end
            W_EXEC: begin
                w_wstate_nxt = W_RESP;
                for (int unsigned i = 0; i < NREGS; i++)
                    if (r_widx == IDX_W'(i)) slv_wr_pulse[i] = 1'b1;
            end
            W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bresp   = r_bresp;

    // Write FSM state, registered readies, captured address/data and response
    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_widx    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_have <= w_aw_have_nxt;
            r_w_have  <= w_w_have_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) && !w_aw_have_nxt;
            r_wready  <= (w_wstate_nxt == W_IDLE) && !w_w_have_nxt;
            if (w_aw_hs) r_widx <= s_axi_awaddr[ADDR_W-1:2];
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (r_wstate == W_EXEC) r_bresp <= w_widx_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Control register storage; out-of-range indices match no word
    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= RST_VAL;
        end else if (r_wstate == W_EXEC) begin
            for (int unsigned i = 0; i < NREGS; i++)
                if (r_widx == IDX_W'(i))
                    for (int unsigned b = 0; b < 4; b++)
                        if (r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
        end
    end

    // Flatten register array onto the slv_reg bus
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) slv_reg[32*i +: 32] = r_regs[i];
    end

    // ---------------- read path ----------------
    rstate_t          r_rstate, w_rstate_nxt;
    logic             r_arready;
    logic [31:0]      r_rdata, w_rd_word;
    logic [1:0]       r_rresp;
    logic [NREGS-1:0] r_rd_pulse, w_rd_mask;
    logic [IDX_W-1:0] w_ar_idx;
    logic             w_ar_hs, w_ar_ok;

    assign w_ar_hs  = s_axi_arvalid & r_arready;
    assign w_ar_idx = s_axi_araddr[ADDR_W-1:2];
    assign w_ar_ok  = int'(w_ar_idx) < NREGS;

    // Read word/pulse select for the address being handshaken
    always_comb begin
        w_rd_word = '0;
        w_rd_mask = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_rd_word    = slv_read[32*i +: 32];
                w_rd_mask[i] = 1'b1;
            end
        end
`ifdef AXIL_REGBANK_ID_EN
        if (w_ar_idx == '0) w_rd_word = ID_VAL;
`endif
    end

    // Read FSM next state and read-side outputs
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign slv_rd_pulse  = r_rd_pulse;

    // Read FSM state; data/resp latched at the AR handshake and held until rready
    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rstate   <= R_IDLE;
            r_arready  <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rstate   <= w_rstate_nxt;
            r_arready  <= (w_rstate_nxt == R_IDLE);
            r_rd_pulse <= w_ar_hs ? w_rd_mask : '0;
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Address LSBs are ignored by design
    logic w_unused_bits;
`ifdef AXIL_REGBANK_ID_EN
    assign w_unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign w_unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], ID_VAL};
`endif

endmodule
